// File: rtl/sum_accumulator.sv
// Running-sum stage for the ripple adder output. It adds COUNT accepted sums and
// presents the total on a valid/ready port until the consumer takes it.
module sum_accumulator #(
  parameter  int N     = 8,
  parameter  int COUNT = 4,
  localparam int ACC_W = N + 1 + $clog2(COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             sum_valid,
  output logic             sum_ready,
  input  logic [N:0]       sum_in,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [7:0]       beat_cnt
);

  // state | meaning
  // ACCUM | taking beats, acc holds the partial total
  // HOLD  | acc_out holds a finished total until acc_ready
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [7:0] LAST = 8'(COUNT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic [ACC_W-1:0] acc_out_nxt;
  logic [7:0]       cnt_nxt;
  logic [ACC_W-1:0] sum_ext;
  logic [ACC_W-1:0] acc_sum;
  logic             accept;
  logic             last_beat;

  // Handshake flags come straight from the state register, so acc_ready never
  // reaches sum_ready combinationally.
  assign sum_ready = (state == ACCUM);
  assign acc_valid = (state == HOLD);
  assign accept    = sum_valid & sum_ready;
  assign last_beat = (beat_cnt == LAST);
  assign sum_ext   = {{(ACC_W - N - 1){1'b0}}, sum_in};
  assign acc_sum   = acc + sum_ext;

  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    cnt_nxt     = beat_cnt;
    acc_out_nxt = acc_out;
    if (clear) begin
      state_nxt = ACCUM;
      acc_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (last_beat) begin
              acc_out_nxt = acc_sum;
              acc_nxt     = '0;
              cnt_nxt     = '0;
              state_nxt   = HOLD;
            end else begin
              acc_nxt = acc_sum;
              cnt_nxt = beat_cnt + 8'd1;
            end
          end
        end
        HOLD: begin
          if (acc_ready) state_nxt = ACCUM;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ACCUM;
      acc      <= '0;
      beat_cnt <= '0;
      acc_out  <= '0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      beat_cnt <= cnt_nxt;
      acc_out  <= acc_out_nxt;
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: COUNT=4 and COUNT=1 instances, directed scenarios
// plus a random run compared against a queue-based model of the handshake.
module tb_sum_accumulator;

  localparam int N      = 8;
  localparam int COUNT  = 4;
  localparam int ACC_W0 = N + 1 + $clog2(COUNT + 1);
  localparam int ACC_W1 = N + 1 + $clog2(1 + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clear = 1'b0;
  logic              sum_valid = 1'b0;
  logic              sum_ready;
  logic [N:0]        sum_in = '0;
  logic              acc_valid;
  logic              acc_ready = 1'b0;
  logic [ACC_W0-1:0] acc_out;
  logic [7:0]        beat_cnt;

  logic              clear1 = 1'b0;
  logic              sum_valid1 = 1'b0;
  logic              sum_ready1;
  logic [N:0]        sum_in1 = '0;
  logic              acc_valid1;
  logic              acc_ready1 = 1'b0;
  logic [ACC_W1-1:0] acc_out1;
  logic [7:0]        beat_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sum_accumulator #(.N(N), .COUNT(COUNT)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_in(sum_in),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_out(acc_out),
    .beat_cnt(beat_cnt)
  );

  sum_accumulator #(.N(N), .COUNT(1)) dut1 (
    .clk(clk), .rst(rst), .clear(clear1),
    .sum_valid(sum_valid1), .sum_ready(sum_ready1), .sum_in(sum_in1),
    .acc_valid(acc_valid1), .acc_ready(acc_ready1), .acc_out(acc_out1),
    .beat_cnt(beat_cnt1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    sum_valid = 1'b0;
    clear     = 1'b0;
    acc_ready = 1'b0;
    rst       = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic send_beat(input logic [N:0] v);
    int n;
    n = 0;
    sum_valid = 1'b1;
    sum_in    = v;
    while (!sum_ready && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (!sum_ready) begin
      errors++;
      $display("FAIL send_beat_timeout: sum_ready=%0b after %0d cycles, required 1", sum_ready, n);
    end
    step();
    sum_valid = 1'b0;
    sum_in    = 9'($urandom_range(0, 510));
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (acc_valid !== 1'b0 || sum_ready !== 1'b1 || beat_cnt !== 8'd0 || acc_out !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%0b ready=%0b cnt=%0d out=%0d, required 0 1 0 0",
               acc_valid, sum_ready, beat_cnt, acc_out);
    end
    send_beat(9'd100);
    send_beat(9'd200);
    checks++;
    if (beat_cnt !== 8'd2) begin
      errors++;
      $display("FAIL reset_precount: beat_cnt=%0d, required 2", beat_cnt);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (beat_cnt !== 8'd0 || sum_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: beat_cnt=%0d ready=%0b, required 0 1", beat_cnt, sum_ready);
    end
    step();
    rst = 1'b0;
    checks++;
    if (acc_valid !== 1'b0 || sum_ready !== 1'b1 || beat_cnt !== 8'd0 || acc_out !== '0) begin
      errors++;
      $display("FAIL reset_midrun: valid=%0b ready=%0b cnt=%0d out=%0d, required 0 1 0 0",
               acc_valid, sum_ready, beat_cnt, acc_out);
    end
    acc_ready = 1'b1;
    send_beat(9'd1);
    send_beat(9'd2);
    send_beat(9'd3);
    send_beat(9'd4);
    checks++;
    if (acc_valid !== 1'b1 || acc_out !== 12'd10) begin
      errors++;
      $display("FAIL reset_discard: valid=%0b out=%0d, required 1 10", acc_valid, acc_out);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    acc_ready = 1'b1;
    send_beat(9'd10);
    send_beat(9'd20);
    send_beat(9'd30);
    checks++;
    if (acc_valid !== 1'b0 || beat_cnt !== 8'd3) begin
      errors++;
      $display("FAIL basic_partial: valid=%0b cnt=%0d, required 0 3", acc_valid, beat_cnt);
    end
    send_beat(9'd40);
    checks++;
    if (acc_valid !== 1'b1 || acc_out !== 12'd100 || sum_ready !== 1'b0 || beat_cnt !== 8'd0) begin
      errors++;
      $display("FAIL basic_result: valid=%0b out=%0d ready=%0b cnt=%0d, required 1 100 0 0",
               acc_valid, acc_out, sum_ready, beat_cnt);
    end
    step();
    checks++;
    if (acc_valid !== 1'b0 || sum_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_bubble: valid=%0b ready=%0b, required 0 1", acc_valid, sum_ready);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    acc_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(9'd510);
    checks++;
    if (acc_valid !== 1'b1 || acc_out !== 12'd2040) begin
      errors++;
      $display("FAIL bp_result: valid=%0b out=%0d, required 1 2040", acc_valid, acc_out);
    end
    sum_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sum_in = 9'($urandom_range(0, 510));
      step();
      checks++;
      if (acc_valid !== 1'b1 || acc_out !== 12'd2040 || sum_ready !== 1'b0 || beat_cnt !== 8'd0) begin
        errors++;
        $display("FAIL bp_hold: cycle=%0d valid=%0b out=%0d ready=%0b cnt=%0d, required 1 2040 0 0",
                 i, acc_valid, acc_out, sum_ready, beat_cnt);
      end
    end
    sum_valid = 1'b0;
    acc_ready = 1'b1;
    step();
    checks++;
    if (sum_ready !== 1'b1 || acc_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: ready=%0b valid=%0b, required 1 0", sum_ready, acc_valid);
    end
  endtask

  task automatic test_gaps();
    logic [N:0] q[$];
    bit         m_hold;
    int         m_out;
    int         results;
    apply_reset();
    m_hold  = 1'b0;
    m_out   = 0;
    results = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      sum_valid = 1'($urandom_range(0, 1));
      sum_in    = 9'($urandom_range(0, 510));
      acc_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (sum_ready !== !m_hold) begin
        errors++;
        $display("FAIL gaps_ready: cycle=%0d ready=%0b, required %0b", cyc, sum_ready, !m_hold);
      end
      if (m_hold) begin
        if (acc_ready) m_hold = 1'b0;
      end else if (sum_valid) begin
        q.push_back(sum_in);
        if (q.size() == COUNT) begin
          m_out = 0;
          foreach (q[k]) m_out += int'(q[k]);
          q.delete();
          m_hold = 1'b1;
          results++;
        end
      end
      step();
      checks++;
      if (acc_valid !== m_hold || beat_cnt !== 8'(q.size()) || (m_hold && acc_out !== 12'(m_out))) begin
        errors++;
        $display("FAIL gaps_state: cycle=%0d valid=%0b cnt=%0d out=%0d, required %0b %0d %0d",
                 cyc, acc_valid, beat_cnt, acc_out, m_hold, q.size(), m_out);
      end
    end
    sum_valid = 1'b0;
    checks++;
    if (results < 5) begin
      errors++;
      $display("FAIL gaps_results: results=%0d, required at least 5", results);
    end
  endtask

  task automatic test_clear();
    apply_reset();
    acc_ready = 1'b1;
    send_beat(9'd5);
    send_beat(9'd7);
    clear     = 1'b1;
    sum_valid = 1'b1;
    sum_in    = 9'd99;
    step();
    clear     = 1'b0;
    sum_valid = 1'b0;
    checks++;
    if (beat_cnt !== 8'd0 || acc_valid !== 1'b0 || sum_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_partial: cnt=%0d valid=%0b ready=%0b, required 0 0 1",
               beat_cnt, acc_valid, sum_ready);
    end
    acc_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(9'd1);
    checks++;
    if (acc_valid !== 1'b1 || acc_out !== 12'd4) begin
      errors++;
      $display("FAIL clear_after: valid=%0b out=%0d, required 1 4", acc_valid, acc_out);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (acc_valid !== 1'b0 || acc_out !== 12'd4 || sum_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_hold: valid=%0b out=%0d ready=%0b, required 0 4 1",
               acc_valid, acc_out, sum_ready);
    end
  endtask

  task automatic test_count_one();
    apply_reset();
    acc_ready1 = 1'b1;
    sum_valid1 = 1'b1;
    sum_in1    = 9'd3;
    step();
    sum_in1 = 9'd9;
    checks++;
    if (acc_valid1 !== 1'b1 || acc_out1 !== 10'd3 || sum_ready1 !== 1'b0) begin
      errors++;
      $display("FAIL count1_first: valid=%0b out=%0d ready=%0b, required 1 3 0",
               acc_valid1, acc_out1, sum_ready1);
    end
    step();
    checks++;
    if (acc_valid1 !== 1'b0 || sum_ready1 !== 1'b1 || beat_cnt1 !== 8'd0) begin
      errors++;
      $display("FAIL count1_bubble: valid=%0b ready=%0b cnt=%0d, required 0 1 0",
               acc_valid1, sum_ready1, beat_cnt1);
    end
    step();
    sum_valid1 = 1'b0;
    checks++;
    if (acc_valid1 !== 1'b1 || acc_out1 !== 10'd9) begin
      errors++;
      $display("FAIL count1_second: valid=%0b out=%0d, required 1 9", acc_valid1, acc_out1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gaps();
    test_clear();
    test_count_one();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
